// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants, display word layout and glyph table for the seven-segment scanner
package sseg_pkg;

  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [3:0] AN_OFF      = 4'hF;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // Active-low g..a patterns; b and d are lowercase so they stay distinct from 8 and 0.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic        lzb;
    logic [3:0]  dp;
    logic [15:0] value;
  } disp_word_t;

endpackage

// File: rtl/sseg_hex_decode.sv
// rtl/sseg_hex_decode.sv - combinational hex nibble to active-low seven-segment pattern
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPH_TABLE[i_hex];

endmodule

// File: rtl/sseg_scan4.sv
// rtl/sseg_scan4.sv - four-digit multiplexed common-anode driver with guard blanking,
// leading-zero blanking and double-buffered updates
module sseg_scan4
  import sseg_pkg::*;
#(
  parameter int DWELL_CYCLES = 100000,
  parameter int GUARD_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        lzb,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  disp_word_t       r_shadow;
  disp_word_t       r_active;
  logic [7:0]       r_seg;
  logic [3:0]       r_an;

  logic             w_cnt_last;
  logic             w_wrap;
  logic [3:0]       w_digit;
  logic [6:0]       w_glyph;
  logic             w_blank;
  logic [7:0]       w_seg_nxt;
  logic [3:0]       w_an_nxt;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_wrap     = enable && w_cnt_last && (r_idx == 2'd3);
  assign w_digit    = r_active.value[{r_idx, 2'b00} +: 4];

  sseg_hex_decode u_decode (
    .i_hex (w_digit),
    .o_seg (w_glyph)
  );

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    w_blank = r_active.lzb && (r_idx != 2'd0);
    for (int k = 0; k < 4; k++) begin
      if ((k >= int'(r_idx)) && (r_active.value[4*k +: 4] != 4'h0)) begin
        w_blank = 1'b0;
      end
    end
  end

  always_comb begin
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_OFF;
    if (enable && (r_cnt >= CNT_GUARD)) begin
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_seg_nxt = {~r_active.dp[r_idx], (w_blank ? GLYPH_BLANK : w_glyph)};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (!enable) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_cnt_last) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Active only follows shadow at frame boundaries while scanning, so a digit never tears mid-frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (load) begin
        r_shadow <= '{lzb: lzb, dp: dp, value: value};
      end
      if (!enable || w_wrap) begin
        r_active <= r_shadow;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign frame = w_wrap;

endmodule

// File: tb/tb_sseg_scan4.sv
// tb/tb_sseg_scan4.sv - randomized self-checking bench for sseg_scan4 against a positional display model
module tb_sseg_scan4;

  localparam int DWELL = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DWELL;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        lzb = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  int checks = 0;
  int failures = 0;

  sseg_scan4 #(.DWELL_CYCLES(DWELL), .GUARD_CYCLES(GUARD), .CNT_W(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .load   (load),
    .value  (value),
    .dp     (dp),
    .lzb    (lzb),
    .seg    (seg),
    .an     (an),
    .frame  (frame)
  );

  initial forever #5 clock = ~clock;

  logic [6:0] tb_glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the frame (0..31) decides which digit and whether it is in guard.
  int          m_pos = 0;
  logic [15:0] m_sh_v = 0, m_ac_v = 0;
  logic [3:0]  m_sh_d = 0, m_ac_d = 0;
  logic        m_sh_l = 0, m_ac_l = 0;
  logic [3:0]  exp_an = 4'hF;
  logic [7:0]  exp_seg = 8'hFF;

  function automatic logic [11:0] render(input logic en, input int pos, input logic [15:0] v,
                                         input logic [3:0] d, input logic lz);
    int digit, nsig;
    logic [3:0] nib;
    logic [6:0] g;
    digit = pos / DWELL;
    if (!en || (pos % DWELL) < GUARD) return {4'hF, 8'hFF};
    nsig = 1;
    for (int k = 0; k < 4; k++) if (((v >> (4*k)) & 16'hF) != 0) nsig = k + 1;
    nib = 4'((v >> (4*digit)) & 16'hF);
    g = (lz && digit >= nsig) ? 7'h7F : tb_glyph[nib];
    return {4'hF ^ 4'(1 << digit), ~d[digit], g};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pos = 0;
      m_sh_v = 0; m_sh_d = 0; m_sh_l = 0;
      m_ac_v = 0; m_ac_d = 0; m_ac_l = 0;
      exp_an = 4'hF; exp_seg = 8'hFF;
    end else begin
      {exp_an, exp_seg} = render(enable, m_pos, m_ac_v, m_ac_d, m_ac_l);
      if (!enable || m_pos == FRAME - 1) begin
        m_ac_v = m_sh_v; m_ac_d = m_sh_d; m_ac_l = m_sh_l;
      end
      if (load) begin
        m_sh_v = value; m_sh_d = dp; m_sh_l = lzb;
      end
      m_pos = enable ? (m_pos + 1) % FRAME : 0;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("model_an", {12'h0, an}, {12'h0, exp_an});
      chk("model_seg", {8'h0, seg}, {8'h0, exp_seg});
      chk("model_frame", {15'h0, frame}, {15'h0, (enable && m_pos == FRAME - 1)});
    end
  end

  task automatic wait_an(input logic [3:0] target, input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (an !== target && n < 100);
    chk({name, "_reached"}, {12'h0, an}, {12'h0, target});
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (frame !== 1'b1 && n < 80);
    chk({name, "_frame"}, {15'h0, frame}, 16'h1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic l);
    value = v; dp = d; lzb = l; load = 1'b1;
    @(negedge clock); #1;
    load = 1'b0;
  endtask

  logic [3:0] an_seq [16] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
                              4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};
  logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

  initial begin
    int nframes;
    repeat (3) @(negedge clock);
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {8'h0, seg}, 16'h00FF);
    chk("rst_frame", {15'h0, frame}, 16'h0);
    #1 reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("t1_an_seq", {12'h0, an}, {12'h0, an_seq[i]});
      if (an != 4'hF) chk("t1_seg_zero", {8'h0, seg}, 16'h00C0);
    end
    nframes = 0;
    repeat (64) begin
      @(negedge clock);
      if (frame) nframes++;
    end
    chk("t1_frame_count", 16'(nframes), 16'd2);

    #1 do_load(16'h12AF, 4'b0100, 1'b0);
    wait_frame("t2");
    wait_an(4'hE, "t2_d0"); chk("t2_d0_seg", {8'h0, seg}, 16'h008E);
    wait_an(4'hD, "t2_d1"); chk("t2_d1_seg", {8'h0, seg}, 16'h0088);
    wait_an(4'hB, "t2_d2"); chk("t2_d2_seg", {8'h0, seg}, 16'h0024);
    wait_an(4'h7, "t2_d3"); chk("t2_d3_seg", {8'h0, seg}, 16'h00F9);

    #1 do_load(16'h0005, 4'b0010, 1'b1);
    wait_frame("t3");
    wait_an(4'hE, "t3_d0"); chk("t3_d0_seg", {8'h0, seg}, 16'h0092);
    wait_an(4'hD, "t3_d1"); chk("t3_d1_seg", {8'h0, seg}, 16'h007F);
    wait_an(4'hB, "t3_d2"); chk("t3_d2_seg", {8'h0, seg}, 16'h00FF);
    wait_an(4'h7, "t3_d3"); chk("t3_d3_seg", {8'h0, seg}, 16'h00FF);

    wait_frame("t4");
    #1 do_load(16'h8000, 4'b0000, 1'b0);
    wait_an(4'hE, "t4_old_d0"); chk("t4_old_d0_seg", {8'h0, seg}, 16'h0092);
    wait_an(4'h7, "t4_old_d3"); chk("t4_old_d3_seg", {8'h0, seg}, 16'h00FF);
    wait_frame("t4_next");
    wait_an(4'hE, "t4_new_d0"); chk("t4_new_d0_seg", {8'h0, seg}, 16'h00C0);
    wait_an(4'h7, "t4_new_d3"); chk("t4_new_d3_seg", {8'h0, seg}, 16'h0080);

    wait_frame("t5_sync");
    wait_an(4'hB, "t5_d2");
    #1 enable = 1'b0;
    @(negedge clock);
    chk("t5_off_an", {12'h0, an}, 16'h000F);
    chk("t5_off_seg", {8'h0, seg}, 16'h00FF);
    #1 do_load(16'h8888, 4'b0000, 1'b0);
    repeat (3) @(negedge clock);
    #1 enable = 1'b1;
    @(negedge clock); chk("t5_guard0_an", {12'h0, an}, 16'h000F);
    @(negedge clock); chk("t5_guard1_an", {12'h0, an}, 16'h000F);
    @(negedge clock);
    chk("t5_d0_an", {12'h0, an}, 16'h000E);
    chk("t5_d0_seg", {8'h0, seg}, 16'h0080);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clock); #1;
      load = ($urandom_range(0, 15) == 0);
      if (load) begin
        value = 16'($urandom) & masks[$urandom_range(0, 4)];
        dp = 4'($urandom);
        lzb = 1'($urandom);
      end
      if ($urandom_range(0, 199) == 0) enable = ~enable;
    end
    @(negedge clock); #1;
    load = 1'b0;
    enable = 1'b1;

    wait_an(4'hD, "t6_d1");
    #2 reset = 1'b0;
    #1;
    chk("t6_async_an", {12'h0, an}, 16'h000F);
    chk("t6_async_seg", {8'h0, seg}, 16'h00FF);
    chk("t6_async_frame", {15'h0, frame}, 16'h0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    wait_an(4'hE, "t6_d0"); chk("t6_d0_seg", {8'h0, seg}, 16'h00C0);
    wait_an(4'hD, "t6_d1b"); chk("t6_d1_seg", {8'h0, seg}, 16'h00C0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg_scan4.md
Name: sseg_scan4

Overview:
- Time-multiplexed driver for the 4-digit common-anode seven-segment display.
- Sits downstream of the counter/value-producing logic and replaces the single-digit decoder at the board pins.
- Latches a 16-bit hex value plus per-digit decimal points, then scans one digit at a time at a fixed dwell rate.
- Includes anti-ghosting guard blanking, optional leading-zero blanking, and tear-free double-buffered updates.

Parameters:
- DWELL_CYCLES, 100000: clock cycles each digit is selected. Must be >= 2.
- GUARD_CYCLES, 1000: cycles at the start of each dwell during which all anodes are off. Must be < DWELL_CYCLES.
- CNT_W, 17: dwell counter width. Must satisfy 2^CNT_W >= DWELL_CYCLES.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan and drive the display; 0 = display dark.
- load  in  1  single-cycle strobe: capture value/dp/lzb into the shadow register.
- value  in  16  four hex digits; value[3:0] is the rightmost digit (digit 0).
- dp  in  4  decimal point per digit; dp[k] belongs to digit k; 1 = lit.
- lzb  in  1  1 = blank leading zero digits.
- seg  out  8  active-low segments: seg[0]=a … seg[6]=g, seg[7]=dp.
- an  out  4  active-low anodes; an[k] selects digit k.
- frame  out  1  one-cycle pulse when the active register is refreshed.

Behaviour:
- Reset (asynchronous, reset=0):
  - dwell counter=0, digit index=0.
  - shadow and active registers = 0.
  - an=4'hF, seg=8'hFF, frame=0.
  - Reset mid-scan forces these values immediately. After release, scanning restarts at digit 0, counter 0.
- Shadow register:
  - On a clock with load=1, capture {lzb, dp, value}.
  - Back-to-back loads: the last one wins. load is honoured regardless of enable.
- Active register (drives the display):
  - enable=1: active <= shadow only on the scan-wrap cycle (counter==DWELL_CYCLES-1 and index==3). frame=1 on that cycle.
  - enable=0: active <= shadow every cycle; frame=0.
  - If load and scan-wrap coincide, active takes the old shadow; the new value appears at the next wrap.
- Scan sequencing (enable=1):
  - Counter runs 0..DWELL_CYCLES-1, then wraps to 0.
  - Index increments on wrap, 0→1→2→3→0.
- enable=0:
  - Counter and index are held at 0.
  - Next cycle: an=4'hF, seg=8'hFF.
  - On re-enable, scanning starts at digit 0 with a full guard period.
- Output registers:
  - an/seg are registered from the current counter/index/active, so they reflect the state with 1-cycle latency.
  - Counter < GUARD_CYCLES: an=4'hF, seg=8'hFF.
  - Otherwise: an = ~(1<<index); seg = {~dp[index], glyph(active digit[index])}.
- Glyphs, active-low g..a:
  - Standard hex set; b and d are lowercase.
  - Reference values with dp off: 0→8'hC0, 1→8'hF9, 8→8'h80, A→8'h88, F→8'h8E.
- Leading-zero blanking (active lzb=1):
  - Digit k (k=1..3) is blanked when active digits k..3 are all 0. Digit 0 is never blanked.
  - A blanked digit drives seg[6:0]=7'h7F; its dp still follows dp[k].
  - Its anode is still asserted, so brightness stays uniform.
- Only one anode is low at any time; there is no overlap between digits.

Decomposition:
- Package sseg_pkg:
  - constants SEG_OFF=8'hFF, AN_OFF=4'hF;
  - 16-entry glyph table (4-bit → 7-bit active-low).
- Sub-module sseg_hex_decode: purely combinational 4-bit → seg[6:0] lookup using the package table. Reused elsewhere in the codebase.
- sseg_scan4 holds: counter, index, shadow/active registers, blanking logic, output registers.

Test Plan (DWELL_CYCLES=8, GUARD_CYCLES=2):
1. Reset, then release with enable=1, no load → every digit shows 0 (seg=8'hC0). an sequence per dwell: F,F, then FE×6; next dwell F,F, FD×6; then FB, F7. frame pulses every 32 cycles.
2. load with value=16'h12AF, dp=4'b0100, lzb=0 mid-scan → display stays 0000 until the next frame pulse. Then digit0=8'h8E, digit1=8'h88, digit2=8'h24 (2 with dp lit), digit3=8'hF9.
3. value=16'h0005, lzb=1, dp=4'b0010 → digit0=8'h92. digit1=8'h7F (blank, dp lit). digits 2–3=8'hFF with anodes still asserted.
4. load pulse on the exact scan-wrap cycle → the old value is shown for one more frame; the new value appears after the following frame pulse.
5. enable=0 mid-dwell on digit 2 → next cycle an=F, seg=FF. While disabled, load 16'h8888. Re-enable → two guard cycles, then digit 0 shows 8'h80 immediately.
6. Assert reset asynchronously mid-dwell (between clock edges) → an=F, seg=FF, frame=0 at once. Active is cleared, so the display shows 0000 after release.
